// File: rtl/ipid_pkg.sv
// Shared IP-ID framing types and default markers, common to the streamer,
// the legacy fixed-width streamer and the receiver-side deframer.
package ipid_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    FINISH
  } state_t;

  localparam logic [15:0] IPID_START_WORD = 16'h7A7A;
  localparam logic [15:0] IPID_STOP_WORD  = 16'hB9B9;

endpackage

// File: rtl/ipid_stream_framer.sv
// Captures an IP identifier and emits it as a framed chunk stream:
// start word, payload chunks, optional XOR checksum, stop word (valid/ready).
module ipid_stream_framer
  import ipid_pkg::*;
#(
  parameter int unsigned          ID_W       = 256,
  parameter int unsigned          CHUNK_W    = 16,
  parameter logic [CHUNK_W-1:0]   START_WORD = CHUNK_W'(IPID_START_WORD),
  parameter logic [CHUNK_W-1:0]   STOP_WORD  = CHUNK_W'(IPID_STOP_WORD),
  parameter bit                   CSUM_EN    = 1'b1,
  parameter bit                   MSB_FIRST  = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic               abort,
  input  logic [ID_W-1:0]    ipid_in,
  input  logic               ready,
  output logic               valid,
  output logic [CHUNK_W-1:0] ipid_chunk,
  output logic               last,
  output logic               busy,
  output logic               done
);

  localparam int unsigned N   = ID_W / CHUNK_W;
  localparam int unsigned L   = N + 2 + (CSUM_EN ? 1 : 0);
  localparam int unsigned CNT_W = $clog2(L + 1);

  if ((ID_W % CHUNK_W) != 0 || ID_W < CHUNK_W) begin : g_bad_width
    $error("ipid_stream_framer: ID_W must be a non-zero multiple of CHUNK_W");
  end

  state_t             state;
  logic [ID_W-1:0]    shadow;
  logic [CNT_W-1:0]   cnt;
  logic [CHUNK_W-1:0] csum;

  logic [CNT_W-1:0]   cnt_nxt;
  logic [CHUNK_W-1:0] beat_nxt;
  logic [CHUNK_W-1:0] csum_nxt;
  logic [CHUNK_W-1:0] payload;
  logic               last_nxt;
  int unsigned        pidx;

  // cnt is the index of the beat currently on the bus; this mux prepares beat cnt+1.
  always_comb begin
    cnt_nxt  = cnt + 1'b1;
    payload  = '0;
    pidx     = 0;
    beat_nxt = STOP_WORD;
    csum_nxt = csum;
    last_nxt = 1'b0;
    if (cnt_nxt <= CNT_W'(N)) begin
      pidx     = MSB_FIRST ? (N - 32'(cnt_nxt)) : (32'(cnt_nxt) - 1);
      payload  = CHUNK_W'(shadow >> (pidx * CHUNK_W));
      beat_nxt = payload;
      csum_nxt = csum ^ payload;
    end else if (CSUM_EN && (cnt_nxt == CNT_W'(N + 1))) begin
      beat_nxt = csum;
    end else begin
      last_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shadow     <= '0;
      cnt        <= '0;
      csum       <= '0;
      valid      <= 1'b0;
      ipid_chunk <= '0;
      last       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go) begin
            shadow     <= ipid_in;
            cnt        <= '0;
            csum       <= '0;
            ipid_chunk <= START_WORD;
            valid      <= 1'b1;
            last       <= 1'b0;
            busy       <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          if (abort) begin
            valid      <= 1'b0;
            ipid_chunk <= '0;
            last       <= 1'b0;
            state      <= FINISH;
          end else if (valid && ready) begin
            if (last) begin
              valid      <= 1'b0;
              ipid_chunk <= '0;
              last       <= 1'b0;
              done       <= 1'b1;
              state      <= FINISH;
            end else begin
              cnt        <= cnt_nxt;
              csum       <= csum_nxt;
              ipid_chunk <= beat_nxt;
              last       <= last_nxt;
            end
          end
        end
        FINISH: begin
          if (!go) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ipid_stream_framer.sv
// Directed and randomized frames on three framer configurations, checked
// against a queue-based reference model of the frame layout.
module tb_ipid_stream_framer;

  logic         clk = 1'b0;
  logic         rst;
  logic         go, go0, go1, go2;
  logic         abort;
  logic         ready;
  logic [255:0] ipid_in;
  logic [63:0]  ipid_in2;

  logic         v0, v1, v2, l0, l1, l2, b0, b1, b2, d0, d1, d2;
  logic [15:0]  c0, c1;
  logic [7:0]   c2;

  logic         ov, ol, ob, od;
  logic [15:0]  oc;

  int           sel;
  int           checks = 0;
  int           errors = 0;
  logic [15:0]  expq[$];

  always #5 clk = ~clk;

  ipid_stream_framer dut0 (
    .clk(clk), .rst(rst), .go(go0), .abort(abort), .ipid_in(ipid_in), .ready(ready),
    .valid(v0), .ipid_chunk(c0), .last(l0), .busy(b0), .done(d0)
  );

  ipid_stream_framer #(.MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .go(go1), .abort(abort), .ipid_in(ipid_in), .ready(ready),
    .valid(v1), .ipid_chunk(c1), .last(l1), .busy(b1), .done(d1)
  );

  ipid_stream_framer #(
    .ID_W(64), .CHUNK_W(8), .START_WORD(8'h7A), .STOP_WORD(8'hB9), .CSUM_EN(1'b0), .MSB_FIRST(1'b0)
  ) dut2 (
    .clk(clk), .rst(rst), .go(go2), .abort(abort), .ipid_in(ipid_in2), .ready(ready),
    .valid(v2), .ipid_chunk(c2), .last(l2), .busy(b2), .done(d2)
  );

  always_comb begin
    go0 = go && (sel == 0);
    go1 = go && (sel == 1);
    go2 = go && (sel == 2);
    case (sel)
      1:       begin ov = v1; oc = c1;         ol = l1; ob = b1; od = d1; end
      2:       begin ov = v2; oc = {8'h00, c2}; ol = l2; ob = b2; od = d2; end
      default: begin ov = v0; oc = c0;         ol = l0; ob = b0; od = d0; end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic [255:0] id);
    ipid_in  = id;
    ipid_in2 = id[63:0];
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference frame: start, payload chunks in the configured order, optional XOR, stop.
  task automatic build(input int s, input logic [255:0] id);
    int unsigned idw, cw, n, idx;
    logic [15:0] st, sp, cs, ch, mask;
    bit ce, mf;
    case (s)
      1:       begin idw = 256; cw = 16; st = 16'h7A7A; sp = 16'hB9B9; ce = 1; mf = 1; end
      2:       begin idw = 64;  cw = 8;  st = 16'h007A; sp = 16'h00B9; ce = 0; mf = 0; end
      default: begin idw = 256; cw = 16; st = 16'h7A7A; sp = 16'hB9B9; ce = 1; mf = 0; end
    endcase
    n    = idw / cw;
    mask = 16'((32'h1 << cw) - 1);
    cs   = '0;
    expq.delete();
    expq.push_back(st);
    for (int unsigned p = 0; p < n; p++) begin
      idx = mf ? (n - 1 - p) : p;
      ch  = 16'(id >> (idx * cw)) & mask;
      cs  = cs ^ ch;
      expq.push_back(ch);
    end
    if (ce) expq.push_back(cs);
    expq.push_back(sp);
  endtask

  task automatic run_frame(input int s, input logic [255:0] id, input int rmode,
                           input int abort_at, input int rst_at, input bit hold_go);
    int beat, cyc, len;
    bit aborted, hold, did_rst;
    build(s, id);
    len = expq.size();
    sel = s;
    hold = hold_go;
    aborted = 0;
    did_rst = 0;
    @(negedge clk);
    set_id(id);
    go = 1'b1;
    @(negedge clk);
    if (!hold) go = 1'b0;
    beat = 0;
    cyc = 0;
    while (beat < len && cyc < 1000) begin
      cyc++;
      set_id(rand256());
      ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ((cyc % 3) == 1) : 1'($urandom_range(0, 1));
      chk("valid", 32'(ov), 1);
      chk("chunk", 32'(oc), 32'(expq[beat]));
      chk("last", 32'(ol), 32'(beat == len - 1));
      chk("busy", 32'(ob), 1);
      chk("done", 32'(od), 0);
      if (beat == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        aborted = 1;
        break;
      end
      if (beat == rst_at && !did_rst) begin
        did_rst = 1;
        #2 rst = 1'b0;
        #1;
        chk("rst_valid", 32'(ov), 0);
        chk("rst_chunk", 32'(oc), 0);
        chk("rst_last", 32'(ol), 0);
        chk("rst_busy", 32'(ob), 0);
        chk("rst_done", 32'(od), 0);
        go = 1'b1;
        hold = 1;
        set_id(id);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        beat = 0;
        continue;
      end
      if (ready) beat++;
      @(negedge clk);
    end
    if (beat < len && !aborted) chk("timeout", 0, 1);
    chk("end_valid", 32'(ov), 0);
    chk("end_chunk", 32'(oc), 0);
    chk("end_last", 32'(ol), 0);
    chk("end_busy", 32'(ob), 1);
    chk("end_done", 32'(od), aborted ? 0 : 1);
    if (hold) begin
      repeat (2) begin
        @(negedge clk);
        chk("hold_valid", 32'(ov), 0);
        chk("hold_busy", 32'(ob), 1);
        chk("hold_done", 32'(od), 0);
      end
      go = 1'b0;
    end
    @(negedge clk);
    chk("idle_busy", 32'(ob), 0);
    chk("idle_done", 32'(od), 0);
    chk("idle_valid", 32'(ov), 0);
  endtask

  initial begin
    logic [255:0] id_a5;
    logic [255:0] id_seq;
    rst = 1'b0;
    go = 1'b0;
    abort = 1'b0;
    ready = 1'b0;
    sel = 0;
    set_id('0);
    #3;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("reset_valid", 32'(ov), 0);
      chk("reset_chunk", 32'(oc), 0);
      chk("reset_last", 32'(ol), 0);
      chk("reset_busy", 32'(ob), 0);
      chk("reset_done", 32'(od), 0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;

    id_a5 = '0;
    id_a5[15:0] = 16'hA5A5;
    id_seq = '0;
    id_seq[63:0] = 64'h0807060504030201;

    run_frame(0, id_a5, 0, -1, -1, 1'b0);
    run_frame(1, id_a5, 0, -1, -1, 1'b0);
    run_frame(0, id_a5, 1, -1, -1, 1'b0);
    run_frame(2, id_seq, 0, -1, -1, 1'b0);
    run_frame(0, rand256(), 0, 3, -1, 1'b1);
    run_frame(0, rand256(), 2, -1, -1, 1'b0);
    run_frame(0, rand256(), 0, -1, 5, 1'b0);
    run_frame(1, rand256(), 1, -1, -1, 1'b1);

    for (int i = 0; i < 8; i++) begin
      run_frame($urandom_range(0, 2), rand256(), 2,
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : -1,
                -1, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ipid_stream_framer.md
# ipid_stream_framer

Parametrised successor to the team's fixed 256-bit IP-ID streamer. It captures an IP identifier of configurable width and emits it as a framed chunk stream: a start word, the payload chunks in configurable order, an optional XOR checksum word, then a stop word. Output uses valid/ready backpressure and supports a synchronous abort. It sits between the IP-ID register bank and the on-chip ID transport / watermark channel.

## Interface
- ID_W, 256, identifier width; must be an integer multiple of CHUNK_W.
- CHUNK_W, 16, output chunk width.
- START_WORD, 16'h7A7A, frame start marker (CHUNK_W bits).
- STOP_WORD, 16'hB9B9, frame stop marker (CHUNK_W bits).
- CSUM_EN, 1, 1 = append XOR checksum word before STOP_WORD.
- MSB_FIRST, 0, 0 = chunk [CHUNK_W-1:0] sent first; 1 = top chunk sent first.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low; clock clk
- go  in  1  level request; sampled in IDLE
- abort  in  1  synchronous frame abort
- ipid_in  in  ID_W  identifier; captured on the go-accept cycle only
- ready  in  1  downstream accepts chunk when valid && ready
- valid  out  1  chunk holds a beat
- ipid_chunk  out  CHUNK_W  current beat
- last  out  1  high with STOP_WORD beat
- busy  out  1  high in SEND and FINISH
- done  out  1  one-cycle pulse after STOP_WORD accepted

## Operation
- N = ID_W/CHUNK_W payload beats; frame length L = N + 2 + CSUM_EN.
- States: IDLE, SEND, FINISH.
- IDLE: on go=1, capture ipid_in into shadow register, clear beat counter and checksum, load START_WORD into ipid_chunk, set valid=1 -> SEND.
- SEND: on each accepted beat, advance counter and load the next beat. Beat 0 is START_WORD. Beats 1..N are payload chunks in MSB_FIRST order. If CSUM_EN, beat N+1 is the XOR of all N payload chunks. The final beat is STOP_WORD with last=1.
- Checksum accumulates as payload beats are loaded, so it is independent of order.
- STOP_WORD accepted: valid=0, last=0, ipid_chunk=0, done=1 for one cycle -> FINISH.
- abort=1 in SEND (priority over handshake): next cycle valid=0, ipid_chunk=0, last=0 -> FINISH. No done pulse.
- abort is ignored in IDLE and FINISH.
- FINISH: stay until go=0, then -> IDLE. A held go never retriggers a frame.
- Backpressure: while valid && !ready, ipid_chunk and last hold stable. A new ipid_in value has no effect mid-frame.

## Timing
- Reset values: valid=0, ipid_chunk=0, last=0, busy=0, done=0; state IDLE; counter, checksum and shadow register 0.
- Reset asserted mid-frame clears everything immediately, regardless of clock.
- Latency: go sampled high at edge k -> START_WORD valid after edge k.
- With ready held high, one beat per cycle. Frame occupies L cycles; done follows the STOP_WORD acceptance edge.
- Minimum go-to-go spacing is L+2 cycles (FINISH plus go low for one cycle).
- Counter width is $clog2(L+1). Counter never exceeds L-1, so there is no wrap-around.
- Elaboration error if ID_W % CHUNK_W != 0 or ID_W < CHUNK_W.

## Structure
- Shared package ipid_pkg holds:
  - the state_t enum {IDLE, SEND, FINISH};
  - default IPID_START_WORD / IPID_STOP_WORD constants, shared with the legacy streamer and the receiver-side deframer.
- No sub-module; the shadow register, chunk mux, counter and checksum register are one always_ff block plus a combinational next-beat mux.

## Test plan
- Defaults, ready=1, ipid_in = 0 except [15:0]=16'hA5A5, go pulse -> beats 7A7A, A5A5, 0000×15, A5A5 (csum), B9B9. last only on B9B9. done 1 cycle later. 19 beats total.
- Same ipid_in with MSB_FIRST=1 -> 7A7A, 0000×15, A5A5, A5A5, B9B9.
- ready toggling 1,0,0,1,… -> no beat duplicated or dropped; chunk stable during every ready=0 cycle; same 19-beat sequence.
- CSUM_EN=0, ID_W=64, CHUNK_W=8, START_WORD=8'h7A, STOP_WORD=8'hB9, ipid_in=64'h0807060504030201 -> 7A,01,02,…,08,B9. Total 10 beats.
- abort on payload beat 3 -> valid=0 next cycle, no done, busy=1 until go deasserts, then idle. Next go sends a complete frame.
- rst low during beat 5 -> all outputs 0 immediately. go held high from before reset release -> new frame starts with START_WORD.
